// File: rtl/axi_read_channel.sv
// AXI4 read master: issues one INCR burst per start request and forwards the
// returned R beats, registered, into the downstream read-data FIFO.
module axi_read_channel #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_M_AXI_BURST_LEN  = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          start_single_burst_read,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] burst_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]                    axi_arlen,
  output logic [2:0]                    axi_arsize,
  output logic [1:0]                    axi_arburst,
  output logic                          axi_arvalid,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          axi_rready,
  input  logic                          read_Fifo_ProgFull,
  output logic [C_M_AXI_DATA_WIDTH-1:0] ReadData,
  output logic                          ReadDataValid,
  output logic                          burst_read_active,
  output logic                          burst_read_done,
  output logic                          read_error
);

  localparam int IDX_W = $clog2(C_M_AXI_BURST_LEN) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_M_AXI_BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] beat_idx;
  logic             arnext, rnext, start_ok, idx_last, resp_err, beat_err, burst_end;

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == LAST_IDX) ? v : v + 1'b1;
  endfunction

  assign axi_arlen   = 8'(C_M_AXI_BURST_LEN - 1);
  assign axi_arsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  assign axi_arburst = 2'b01;

  assign arnext    = axi_arvalid & M_AXI_ARREADY;
  assign rnext     = axi_rready & M_AXI_RVALID;
  assign start_ok  = start_single_burst_read & (state == IDLE);
  assign idx_last  = (beat_idx == LAST_IDX);
  // SLVERR and DECERR both have RRESP[1] set
  assign resp_err  = (M_AXI_RRESP == 2'b10) | (M_AXI_RRESP == 2'b11);
  assign beat_err  = resp_err | (M_AXI_RLAST & ~idx_last) | (~M_AXI_RLAST & idx_last);
  assign burst_end = rnext & (M_AXI_RLAST | idx_last);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)  state_nxt = ADDR;
      ADDR:    if (arnext)    state_nxt = DATA;
      DATA:    if (burst_end) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Only DATA may accept beats; prog-full threshold leaves slack for the in-flight beat
  always_comb begin
    axi_rready = (state == DATA) & ~read_Fifo_ProgFull;
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      axi_araddr        <= '0;
      axi_arvalid       <= 1'b0;
      ReadData          <= '0;
      ReadDataValid     <= 1'b0;
      burst_read_active <= 1'b0;
      burst_read_done   <= 1'b0;
      read_error        <= 1'b0;
      beat_idx          <= '0;
    end else begin
      ReadDataValid   <= rnext;
      burst_read_done <= burst_end;
      if (rnext) ReadData <= M_AXI_RDATA;
      if (start_ok) begin
        axi_araddr        <= burst_addr;
        axi_arvalid       <= 1'b1;
        burst_read_active <= 1'b1;
        read_error        <= 1'b0;
        beat_idx          <= '0;
      end else begin
        if (arnext) axi_arvalid <= 1'b0;
        if (rnext) begin
          beat_idx <= sat_inc(beat_idx);
          if (beat_err) read_error <= 1'b1;
        end
        if (burst_end) burst_read_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_channel.sv
// Directed bench for axi_read_channel: the driver queues expected beats and
// completions as it issues them; a negedge monitor pops and compares.
module tb_axi_read_channel;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] burst_addr;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          axi_rready;
  logic          prog_full;
  logic [DW-1:0] ReadData;
  logic          ReadDataValid;
  logic          burst_read_active;
  logic          burst_read_done;
  logic          read_error;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  typedef struct {logic [DW-1:0] data; longint at;} beat_t;
  typedef struct {logic err; longint at;} done_t;
  beat_t data_q[$];
  done_t done_q[$];
  logic [DW-1:0] last_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_read_channel #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_BURST_LEN (BL)
  ) dut (
    .M_AXI_ACLK             (clk),
    .M_AXI_ARESETN          (rst_n),
    .start_single_burst_read(start),
    .burst_addr             (burst_addr),
    .axi_araddr             (axi_araddr),
    .axi_arlen              (axi_arlen),
    .axi_arsize             (axi_arsize),
    .axi_arburst            (axi_arburst),
    .axi_arvalid            (axi_arvalid),
    .M_AXI_ARREADY          (arready),
    .M_AXI_RDATA            (rdata),
    .M_AXI_RRESP            (rresp),
    .M_AXI_RLAST            (rlast),
    .M_AXI_RVALID           (rvalid),
    .axi_rready             (axi_rready),
    .read_Fifo_ProgFull     (prog_full),
    .ReadData               (ReadData),
    .ReadDataValid          (ReadDataValid),
    .burst_read_active      (burst_read_active),
    .burst_read_done        (burst_read_done),
    .read_error             (read_error)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [7:0] base, input int k);
    return {base, 112'h0, 8'(k)};
  endfunction

  task automatic idle_inputs();
    start     = 1'b0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = 2'b00;
    rdata     = '0;
    prog_full = 1'b0;
  endtask

  // Monitor: every forwarded beat and every done pulse must match the queued expectation
  always @(negedge clk) begin
    beat_t eb;
    done_t ed;
    if (!rst_n) begin
      last_data = '0;
    end else begin
      if (ReadDataValid) begin
        if (data_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          eb = data_q.pop_front();
          chk("rdata", ReadData, eb.data);
          chk("rdata_cycle", DW'(cyc), DW'(eb.at));
          last_data = eb.data;
        end
      end else begin
        chk("rdata_hold", ReadData, last_data);
      end
      if (burst_read_done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          ed = done_q.pop_front();
          chk("read_error_at_done", read_error, ed.err);
          chk("done_cycle", DW'(cyc), DW'(ed.at));
          chk("active_at_done", burst_read_active, 0);
        end
      end
    end
  end

  // Entered and left at a negedge. -1 disables last_at/err_at/start_again_at/abort_at.
  task automatic run_burst(input logic [AW-1:0] addr, input int ar_delay, input int last_at,
                           input int err_at, input bit pf_test, input int start_again_at,
                           input int abort_at, input logic [7:0] base, input bit exp_err);
    int k = 0;
    int stalled_k = -1;
    chk("active_before_start", burst_read_active, 0);
    start      = 1'b1;
    burst_addr = addr;
    @(negedge clk);
    start      = 1'b0;
    burst_addr = ~addr;
    chk("read_error_cleared", read_error, 0);
    chk("active_after_start", burst_read_active, 1);
    for (int i = 0; i <= ar_delay; i++) begin
      arready = (i == ar_delay);
      rvalid  = 1'b1;
      rdata   = mk(base, 0);
      #1;
      chk("arvalid_in_addr", axi_arvalid, 1);
      chk("araddr", axi_araddr, addr);
      chk("rready_in_addr", axi_rready, 0);
      @(negedge clk);
    end
    arready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      logic pf;
      pf = 1'b0;
      if (pf_test && k >= 4 && k <= 7 && stalled_k != k) begin
        pf = 1'b1;
        stalled_k = k;
      end
      prog_full = pf;
      start     = (c == start_again_at);
      rvalid    = 1'b1;
      rdata     = mk(base, k);
      rlast     = (k == last_at);
      rresp     = (k == err_at) ? 2'b10 : 2'b00;
      #1;
      if (k == abort_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_araddr", axi_araddr, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_rdata", ReadData, 0);
        chk("rst_rdvalid", ReadDataValid, 0);
        chk("rst_active", burst_read_active, 0);
        chk("rst_done", burst_read_done, 0);
        chk("rst_error", read_error, 0);
        chk("rst_pending_beats", DW'(data_q.size()), 0);
        data_q.delete();
        done_q.delete();
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      chk("arvalid_in_data", axi_arvalid, 0);
      chk("rready", axi_rready, !pf);
      if (axi_rready) begin
        data_q.push_back('{mk(base, k), cyc + 1});
        if (k == last_at || k == BL - 1) begin
          done_q.push_back('{exp_err, cyc + 1});
          @(negedge clk);
          idle_inputs();
          return;
        end
        k++;
      end
      @(negedge clk);
    end
    chk("burst_timeout", 1, 0);
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    burst_addr = '0;
    idle_inputs();
    @(negedge clk);
    #1;
    chk("reset_arvalid", axi_arvalid, 0);
    chk("reset_araddr", axi_araddr, 0);
    chk("reset_rready", axi_rready, 0);
    chk("reset_rdvalid", ReadDataValid, 0);
    chk("reset_active", burst_read_active, 0);
    chk("reset_done", burst_read_done, 0);
    chk("reset_error", read_error, 0);
    chk("arlen", axi_arlen, 15);
    chk("arsize", axi_arsize, 4);
    chk("arburst", axi_arburst, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    run_burst(32'h0000_1000, 0, 15, -1, 1'b0, -1, -1, 8'h01, 1'b0);
    run_burst(32'h0000_1000, 5, 15, -1, 1'b0, -1, -1, 8'h02, 1'b0);
    run_burst(32'h0000_2000, 0, 15, -1, 1'b1, -1, -1, 8'h00, 1'b0);
    run_burst(32'h0000_3000, 0,  9, -1, 1'b0, -1, -1, 8'h04, 1'b1);
    run_burst(32'h0000_3400, 0, 15, -1, 1'b0, -1, -1, 8'h05, 1'b0);
    run_burst(32'h0000_4000, 0, 15,  3, 1'b0, -1, -1, 8'h06, 1'b1);
    run_burst(32'h0000_5000, 0, 15, -1, 1'b0,  5, -1, 8'h07, 1'b0);
    run_burst(32'h0000_6000, 0, 15, -1, 1'b0, -1,  8, 8'h08, 1'b0);
    run_burst(32'h0000_7000, 0, 15, -1, 1'b0, -1, -1, 8'h09, 1'b0);

    repeat (4) @(negedge clk);
    #1;
    chk("beats_outstanding", DW'(data_q.size()), 0);
    chk("dones_outstanding", DW'(done_q.size()), 0);
    chk("final_active", burst_read_active, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_read_channel.md
Name: axi_read_channel

Overview:
- AXI4 read-side master for the DDR FIFO. Issues one INCR burst on the AR channel for each start request.
- Accepts the R-channel beats and forwards them, registered, into the downstream read-data FIFO.
- Throttles RREADY on that FIFO's programmable-full flag. Counterpart of the write data channel on the DDR write path.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 128, AXI data width in bits.
- C_M_AXI_BURST_LEN, 16, beats per burst; legal range 1..256.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- start_single_burst_read  in  1  one-cycle request; honoured only in IDLE.
- burst_addr  in  ADDR_WIDTH  burst start address; sampled with the start request.
- axi_araddr  out  ADDR_WIDTH  AR address.
- axi_arlen  out  8  constant C_M_AXI_BURST_LEN-1.
- axi_arsize  out  3  constant clog2(DATA_WIDTH/8).
- axi_arburst  out  2  constant 2'b01 (INCR).
- axi_arvalid  out  1  AR valid.
- M_AXI_ARREADY  in  1  AR ready.
- M_AXI_RDATA  in  DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat.
- M_AXI_RVALID  in  1  R valid.
- axi_rready  out  1  R ready.
- read_Fifo_ProgFull  in  1  downstream FIFO programmable full.
- ReadData  out  DATA_WIDTH  data to the downstream FIFO.
- ReadDataValid  out  1  write enable to the downstream FIFO.
- burst_read_active  out  1  high from start acceptance until burst completion.
- burst_read_done  out  1  one-cycle pulse at burst completion.
- read_error  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (async assert, sync release): state IDLE. axi_araddr=0, axi_arvalid=0, ReadData=0, ReadDataValid=0, burst_read_active=0, burst_read_done=0, read_error=0, beat index=0. axi_rready=0 (derived from state).
- Handshake terms: arnext = axi_arvalid & M_AXI_ARREADY; rnext = axi_rready & M_AXI_RVALID.
- FSM states are IDLE, ADDR and DATA.
- IDLE, on start:
  - latch burst_addr into axi_araddr;
  - set axi_arvalid and burst_read_active;
  - clear read_error and the beat index;
  - go to ADDR.
  - Start in any other state is ignored; no queueing.
- ADDR:
  - axi_arvalid holds high and axi_araddr holds stable until arnext.
  - On arnext: axi_arvalid=0, go to DATA.
  - ARREADY may already be high in the first ADDR cycle; this gives a one-cycle AR handshake.
- DATA:
  - axi_rready = (state==DATA) & ~read_Fifo_ProgFull. Combinational from the registered state and the FIFO flag.
  - The FIFO prog-full threshold leaves at least 2 free entries.
  - RDATA and RVALID arriving during ADDR are not accepted (rready=0).
- Data path, 1-cycle latency:
  - On rnext: ReadData <= M_AXI_RDATA.
  - ReadDataValid <= rnext every cycle, so it is a registered single-cycle strobe per beat.
  - ReadData holds its value when there is no rnext.
- Beat index: width clog2(BURST_LEN)+1; incremented on each rnext and saturates at BURST_LEN-1.
- Burst termination: on the rnext where (M_AXI_RLAST or index==BURST_LEN-1), whichever comes first:
  - go to IDLE;
  - burst_read_done=1 for exactly one cycle;
  - burst_read_active=0 in the same cycle as done.
- read_error is set (sticky) on any rnext with any of:
  - M_AXI_RRESP[1]==1 (SLVERR or DECERR);
  - RLAST=1 while index!=BURST_LEN-1 (early last);
  - RLAST=0 while index==BURST_LEN-1 (missing last).
  - Data from erroneous beats is still forwarded.
- BURST_LEN==1: the first beat is both first and last; RLAST is expected on it.
- A new start is accepted earliest in the cycle after done, i.e. back-to-back bursts have one IDLE cycle.
- Reset asserted mid-burst: all outputs return to reset values immediately. Outstanding beats are the interconnect's concern.
- arnext and RVALID in the same cycle: the beat is not accepted; it is taken in DATA the next cycle.

Test Plan:
- BURST_LEN=16, addr 0x0000_1000, ARREADY=1, RVALID continuous, RLAST on beat 15, ProgFull=0:
  - AR accepted the cycle after start; 16 ReadDataValid pulses, each 1 cycle after its R beat;
  - done 1 cycle after the last beat; read_error=0.
- Same burst with ARREADY delayed 5 cycles:
  - axi_arvalid and axi_araddr=0x1000 stable for 6 cycles;
  - no rready before arnext.
- ProgFull high during beats 4-7:
  - axi_rready=0 in those cycles; no beats lost;
  - ReadData sequence 0..15 intact; done after 16 beats.
- RLAST asserted on beat 9:
  - burst ends after 10 beats; done pulses; read_error=1.
  - A following start clears read_error; the next clean burst leaves it 0.
- RRESP=2'b10 on beat 3:
  - all 16 beats are still forwarded; read_error=1 at done.
- Start pulsed again during DATA: ignored, AR issued once.
- Async reset asserted at beat 8:
  - all outputs are 0 immediately; state IDLE;
  - a new start after release runs a full clean burst.
